count_seq_monitor: RTL

- Downstream consumer of the 2-bit up-counter output. Samples the count on qualified cycles and checks that it follows the +1 modulo-2^CNT_W sequence (0,1,2,3,0,...).
- Acquires lock after LOCK_N consecutive correct steps.
- Counts full wraps and sequence errors, and raises a sticky error flag.
- Serves as an in-design health monitor and a verification aid for the counter stage.

---
 rtl/count_pkg.sv | 17 +
 rtl/sat_counter.sv | 22 ++
 rtl/count_seq_monitor.sv | 103 ++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the up-counter stage and its sequence monitor.
package count_pkg;

  localparam int unsigned CNT_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Successor of a count value; wraps from max to 0 with no carry out.
  function automatic logic [CNT_W_DEF-1:0] next_count(input logic [CNT_W_DEF-1:0] value);
    return value + CNT_W_DEF'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that a sampled count follows the +1 modulo sequence; tracks lock, wraps and errors.
module count_seq_monitor
  import count_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned LOCK_N = 2,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [CNT_W-1:0]  count,
  input  logic              clear,
  output logic              locked,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_sticky,
  output logic              err_pulse
);

  localparam int unsigned      GOOD_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [CNT_W-1:0]  prev;
  logic [CNT_W-1:0]  expected;
  logic [GOOD_W-1:0] good_cnt;
  logic              match;
  logic              err_hit;
  logic              wrap_hit;
  logic              lock_reached;

  // The shared successor function only covers the default width.
  if (CNT_W == CNT_W_DEF) begin : g_pkg_next
    always_comb expected = next_count(prev);
  end else begin : g_local_next
    always_comb expected = prev + CNT_W'(1);
  end

  assign match        = (count == expected);
  assign err_hit      = sample_en && !clear && (state == LOCKED) && !match;
  assign wrap_hit     = sample_en && !clear && (state == LOCKED) && match &&
                        (prev == CNT_MAX) && (count == '0);
  assign lock_reached = (GOOD_W'(good_cnt + GOOD_W'(1)) == GOOD_W'(LOCK_N));
  assign locked       = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      good_cnt   <= '0;
      wrap_count <= '0;
      err_sticky <= 1'b0;
      err_pulse  <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      prev       <= '0;
      good_cnt   <= '0;
      wrap_count <= '0;
      err_sticky <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= err_hit;
      if (err_hit) err_sticky <= 1'b1;
      if (wrap_hit) wrap_count <= wrap_count + WRAP_W'(1);
      if (sample_en) begin
        prev <= count;
        unique case (state)
          IDLE: begin
            good_cnt <= '0;
            state    <= TRACK;
          end
          TRACK: begin
            if (match) begin
              good_cnt <= good_cnt + GOOD_W'(1);
              if (lock_reached) state <= LOCKED;
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            // Any mismatch, including a repeated value, forces a relock.
            if (!match) begin
              good_cnt <= '0;
              state    <= TRACK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (err_hit),
    .q   (err_count)
  );

endmodule
